// File: rtl/dev_package.sv
// Shared types for the elastic pipeline: payload register flavour and stage bound.
package dev_package;

  typedef enum logic {
    DFF   = 1'b0,
    DFF_R = 1'b1
  } dff_type_t;

  localparam int MAX_STAGES = 64;

endpackage

// File: rtl/d_elastic_pipe_if.sv
// Upstream/downstream bundle of the elastic pipeline, seen from the pipe as slave.
interface d_elastic_pipe_if #(
  parameter type T      = bit,
  parameter int  STAGES = 2
);
  localparam int CW = $clog2(STAGES + 1);

  // Handshake: a payload moves upstream->pipe when in_valid && out_ready, and
  // pipe->downstream when out_valid && in_ready, both sampled at the same rising
  // edge. A valid payload is never withdrawn or altered while it waits for ready.
  T              in_value;
  logic          in_valid;
  logic          out_ready;
  T              out_value;
  logic          out_valid;
  logic          in_ready;
  logic          in_flush;
  logic [CW-1:0] out_count;

  modport master (
    output in_value, in_valid, in_ready, in_flush,
    input  out_ready, out_value, out_valid, out_count
  );

  modport slave (
    input  in_value, in_valid, in_ready, in_flush,
    output out_ready, out_value, out_valid, out_count
  );

endinterface

// File: rtl/d_elastic_stage.sv
// One pipeline stage: payload register, valid bit and pass-through ready.
module d_elastic_stage #(
  parameter type T = bit
) (
  input  logic clk,
  input  logic clear,
  input  logic wipe,
  input  T     up_value,
  input  logic up_valid,
  input  logic down_ready,
  output logic ready,
  output T     value,
  output logic valid
);

  // An empty stage is always ready, so stalled payloads slide into bubbles.
  assign ready = !valid || down_ready;

  always_ff @(posedge clk) begin
    if (clear) begin
      valid <= 1'b0;
    end else if (ready) begin
      valid <= up_valid;
    end
  end

  always_ff @(posedge clk) begin
    if (wipe) begin
      value <= '0;
    end else if (!clear && ready && up_valid) begin
      value <= up_value;
    end
  end

endmodule

// File: rtl/d_elastic_pipe.sv
// Elastic register pipeline: a chain of stages with bubble collapse, flush/reset
// gating and a registered occupancy count.
module d_elastic_pipe
  import dev_package::*;
#(
  parameter type       T        = bit,
  parameter int        STAGES   = 2,
  parameter dff_type_t DFF_TYPE = DFF
) (
  input logic             in_clock,
  input logic             in_reset,
  d_elastic_pipe_if.slave bus
);
  localparam int CW = $clog2(STAGES + 1);

  if (STAGES < 1 || STAGES > MAX_STAGES) begin : g_bad_stages
    $error("d_elastic_pipe: STAGES must be within 1..64");
  end

  logic          clear;
  logic          wipe;
  logic          up_xfer;
  logic          dn_xfer;
  logic [CW-1:0] count_q;

  assign clear = in_reset | bus.in_flush;
  assign wipe  = in_reset & (DFF_TYPE == DFF_R);

  for (genvar k = 0; k < STAGES; k++) begin : g_stage
    T     up_value;
    T     value;
    logic up_valid;
    logic down_ready;
    logic ready;
    logic valid;

    if (k == 0) begin : g_head
      assign up_value = bus.in_value;
      assign up_valid = bus.in_valid;
    end else begin : g_body
      assign up_value = g_stage[k-1].value;
      assign up_valid = g_stage[k-1].valid;
    end

    if (k == STAGES - 1) begin : g_tail
      assign down_ready = bus.in_ready;
    end else begin : g_link
      assign down_ready = g_stage[k+1].ready;
    end

    d_elastic_stage #(.T(T)) u_stage (
      .clk        (in_clock),
      .clear      (clear),
      .wipe       (wipe),
      .up_value   (up_value),
      .up_valid   (up_valid),
      .down_ready (down_ready),
      .ready      (ready),
      .value      (value),
      .valid      (valid)
    );
  end

  // Reset blocks intake outright; a flush swallows whatever is offered.
  assign bus.out_ready = in_reset ? 1'b0 : (bus.in_flush ? 1'b1 : g_stage[0].ready);
  assign bus.out_value = g_stage[STAGES-1].value;
  assign bus.out_valid = g_stage[STAGES-1].valid;
  assign bus.out_count = count_q;

  assign up_xfer = bus.in_valid & g_stage[0].ready;
  assign dn_xfer = g_stage[STAGES-1].valid & bus.in_ready;

  // Internal moves keep the population constant, so only the two ends count.
  always_ff @(posedge in_clock) begin
    if (clear) begin
      count_q <= '0;
    end else begin
      count_q <= count_q + CW'(up_xfer) - CW'(dn_xfer);
    end
  end

endmodule

// File: tb/tb_d_elastic_pipe.sv
// Bench for d_elastic_pipe: a scoreboarded 3-stage pipe plus directed 4- and 2-stage cases.
module tb_d_elastic_pipe;
  import dev_package::*;

  logic clk;
  logic rst3, rst4, rst2;

  int n_cmp = 0;
  int n_err = 0;

  logic [7:0] exp_q[$];
  int         in_q[$];
  int         last_dep = -100;
  int         cyc = 0;

  d_elastic_pipe_if #(.T(logic [7:0]), .STAGES(3)) bus3 ();
  d_elastic_pipe_if #(.T(logic [7:0]), .STAGES(4)) bus4 ();
  d_elastic_pipe_if #(.T(logic [7:0]), .STAGES(2)) bus2r ();
  d_elastic_pipe_if #(.T(logic [7:0]), .STAGES(2)) bus2d ();

  d_elastic_pipe #(.T(logic [7:0]), .STAGES(3), .DFF_TYPE(DFF)) u3 (
    .in_clock (clk), .in_reset (rst3), .bus (bus3));
  d_elastic_pipe #(.T(logic [7:0]), .STAGES(4), .DFF_TYPE(DFF)) u4 (
    .in_clock (clk), .in_reset (rst4), .bus (bus4));
  d_elastic_pipe #(.T(logic [7:0]), .STAGES(2), .DFF_TYPE(DFF_R)) u2r (
    .in_clock (clk), .in_reset (rst2), .bus (bus2r));
  d_elastic_pipe #(.T(logic [7:0]), .STAGES(2), .DFF_TYPE(DFF)) u2d (
    .in_clock (clk), .in_reset (rst2), .bus (bus2d));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    assert (got === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
    end
  endtask

  // Compares the 3-stage pipe against the queue model, then advances one edge.
  task automatic tick();
    logic exp_valid;
    logic exp_ready;
    int   head_at;
    #1;
    exp_ready = rst3 ? 1'b0 : (bus3.in_flush ? 1'b1 : ((exp_q.size() < 3) || bus3.in_ready));
    exp_valid = 1'b0;
    if (exp_q.size() > 0) begin
      head_at = in_q[0] + 3;
      if (last_dep + 1 > head_at) head_at = last_dep + 1;
      exp_valid = (cyc >= head_at);
    end
    chk("p3_valid", bus3.out_valid, exp_valid);
    chk("p3_ready", bus3.out_ready, exp_ready);
    chk("p3_count", bus3.out_count, exp_q.size());
    if (exp_valid) chk("p3_value", bus3.out_value, exp_q[0]);
    if (rst3 || bus3.in_flush) begin
      exp_q.delete();
      in_q.delete();
    end else begin
      if (exp_valid && bus3.in_ready) begin
        void'(exp_q.pop_front());
        void'(in_q.pop_front());
        last_dep = cyc;
      end
      if (bus3.in_valid && exp_ready) begin
        exp_q.push_back(bus3.in_value);
        in_q.push_back(cyc);
      end
    end
    cyc++;
    @(posedge clk);
    #1;
  endtask

  task automatic drive3(input logic v, input logic [7:0] val, input logic rdy, input logic fl);
    bus3.in_valid = v;
    bus3.in_value = val;
    bus3.in_ready = rdy;
    bus3.in_flush = fl;
  endtask

  task automatic drive2(input logic v, input logic [7:0] val, input logic rdy);
    bus2r.in_valid = v;
    bus2r.in_value = val;
    bus2r.in_ready = rdy;
    bus2d.in_valid = v;
    bus2d.in_value = val;
    bus2d.in_ready = rdy;
  endtask

  initial begin
    rst3 = 1'b1; rst4 = 1'b1; rst2 = 1'b1;
    drive3(1'b0, 8'h00, 1'b0, 1'b0);
    drive2(1'b0, 8'h00, 1'b0);
    bus2r.in_flush = 1'b0;
    bus2d.in_flush = 1'b0;
    bus4.in_valid = 1'b0; bus4.in_value = 8'h00; bus4.in_ready = 1'b0; bus4.in_flush = 1'b0;
    @(posedge clk);
    #1;
    tick();
    rst3 = 1'b0; rst4 = 1'b0; rst2 = 1'b0;

    // streaming, in_ready held high
    for (int i = 1; i <= 5; i++) begin
      drive3(1'b1, 8'(i), 1'b1, 1'b0);
      tick();
    end
    drive3(1'b0, 8'h00, 1'b1, 1'b0);
    repeat (5) tick();

    // backpressure: fourth payload waits until the pipe drains
    for (int i = 0; i < 4; i++) begin
      drive3(1'b1, 8'hA0 + 8'(i), 1'b0, 1'b0);
      tick();
    end
    chk("bp_count", bus3.out_count, 3);
    drive3(1'b1, 8'hA3, 1'b1, 1'b0);
    tick();
    drive3(1'b0, 8'h00, 1'b1, 1'b0);
    repeat (6) tick();

    // flush on a full pipe with a simultaneous offer
    for (int i = 0; i < 3; i++) begin
      drive3(1'b1, 8'hB0 + 8'(i), 1'b0, 1'b0);
      tick();
    end
    drive3(1'b1, 8'h55, 1'b0, 1'b1);
    tick();
    drive3(1'b0, 8'h00, 1'b1, 1'b0);
    chk("flush_valid", bus3.out_valid, 1'b0);
    chk("flush_count", bus3.out_count, 0);
    repeat (6) tick();

    // reset mid-stream, offer during reset must be refused
    drive3(1'b1, 8'hC0, 1'b1, 1'b0);
    tick();
    drive3(1'b1, 8'hC1, 1'b1, 1'b0);
    tick();
    rst3 = 1'b1;
    drive3(1'b1, 8'hC9, 1'b1, 1'b0);
    tick();
    rst3 = 1'b0;
    drive3(1'b1, 8'hC2, 1'b1, 1'b0);
    tick();
    drive3(1'b0, 8'h00, 1'b1, 1'b0);
    repeat (5) tick();

    // random traffic
    for (int i = 0; i < 10000; i++) begin
      drive3(1'($urandom_range(0, 1)), 8'($urandom_range(0, 255)),
             1'($urandom_range(0, 99) < 50), 1'($urandom_range(0, 63) == 0));
      rst3 = ($urandom_range(0, 255) == 0);
      tick();
    end
    rst3 = 1'b0;
    drive3(1'b0, 8'h00, 1'b0, 1'b1);
    tick();
    drive3(1'b0, 8'h00, 1'b0, 1'b0);

    // bubble collapse on the 4-stage pipe
    bus4.in_ready = 1'b0;
    bus4.in_valid = 1'b1; bus4.in_value = 8'h11;
    tick();
    bus4.in_valid = 1'b0;
    tick();
    bus4.in_valid = 1'b1; bus4.in_value = 8'h22;
    tick();
    bus4.in_valid = 1'b0;
    repeat (4) tick();
    chk("bub_count", bus4.out_count, 2);
    chk("bub_ready", bus4.out_ready, 1'b1);
    chk("bub_valid", bus4.out_valid, 1'b1);
    chk("bub_value0", bus4.out_value, 8'h11);
    bus4.in_ready = 1'b1;
    tick();
    chk("bub_value1", bus4.out_value, 8'h22);
    chk("bub_valid1", bus4.out_valid, 1'b1);
    chk("bub_count1", bus4.out_count, 1);
    tick();
    chk("bub_empty", bus4.out_valid, 1'b0);
    chk("bub_count0", bus4.out_count, 0);
    bus4.in_ready = 1'b0;

    // reset with and without payload clearing on two 2-stage pipes
    drive2(1'b1, 8'h7E, 1'b0);
    tick();
    drive2(1'b1, 8'h7F, 1'b0);
    tick();
    drive2(1'b0, 8'h00, 1'b0);
    tick();
    chk("r_pre_count", bus2r.out_count, 2);
    chk("r_pre_value", bus2r.out_value, 8'h7E);
    chk("d_pre_value", bus2d.out_value, 8'h7E);
    rst2 = 1'b1;
    #1;
    chk("r_rst_ready", bus2r.out_ready, 1'b0);
    chk("d_rst_ready", bus2d.out_ready, 1'b0);
    tick();
    rst2 = 1'b0;
    chk("r_valid", bus2r.out_valid, 1'b0);
    chk("r_value", bus2r.out_value, 8'h00);
    chk("r_count", bus2r.out_count, 0);
    chk("d_valid", bus2d.out_valid, 1'b0);
    chk("d_value", bus2d.out_value, 8'h7E);
    chk("d_count", bus2d.out_count, 0);
    drive2(1'b1, 8'h33, 1'b1);
    tick();
    drive2(1'b0, 8'h00, 1'b1);
    chk("r_lat1", bus2r.out_valid, 1'b0);
    tick();
    chk("r_lat2", bus2r.out_valid, 1'b1);
    chk("r_out", bus2r.out_value, 8'h33);
    chk("d_out", bus2d.out_value, 8'h33);
    tick();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/d_elastic_pipe.md
D_ELASTIC_PIPE -- requirements
Module: d_elastic_pipe

Interface
REQ-001 SHALL have parameter T, default bit: payload type carried by every stage.
REQ-002 SHALL have parameter STAGES, default 2: number of register stages, legal range 1..64; elaboration error outside this range.
REQ-003 SHALL have parameter DFF_TYPE (dff_type_t), default DFF: DFF leaves payload registers unreset; DFF_R clears payload registers to 0 on reset.
REQ-004 in_clock  input  1  single clock; all state updates on its rising edge.
REQ-005 in_reset  input  1  reset, synchronous and active-high.
REQ-006 in_value  input  T  upstream payload.
REQ-007 in_valid  input  1  upstream payload present.
REQ-008 out_ready  output  1  pipe accepts in_value this cycle.
REQ-009 out_value  output  T  payload of the last stage.
REQ-010 out_valid  output  1  last stage holds a payload.
REQ-011 in_ready  input  1  downstream accepts out_value this cycle.
REQ-012 in_flush  input  1  synchronous discard of all held payloads.
REQ-013 out_count  output  $clog2(STAGES+1)  number of occupied stages.

Function
REQ-014 Each stage k (0..STAGES-1) SHALL hold one payload register and one valid bit; stage 0 faces upstream and stage STAGES-1 drives out_value/out_valid.
REQ-015 Stage k SHALL be ready when its valid bit is 0 or stage k+1 is ready; stage STAGES-1 uses in_ready as its downstream ready.
REQ-016 out_ready SHALL equal stage 0 ready, computed combinationally in the same cycle.
REQ-017 A transfer into stage k SHALL occur when stage k is ready and its upstream is valid; the stage then loads the upstream payload and sets its valid bit.
REQ-018 When stage k is ready and its upstream is not valid, stage k SHALL clear its valid bit; its payload register SHALL hold its value.
REQ-019 An upstream transfer SHALL occur iff in_valid and out_ready are both 1 in the same cycle; a downstream transfer SHALL occur iff out_valid and in_ready are both 1 in the same cycle.
REQ-020 Bubbles SHALL collapse: a stalled payload moves forward whenever the next stage is empty, regardless of in_ready.
REQ-021 Latency from an upstream transfer to out_valid=1 on an empty pipe SHALL be STAGES cycles; sustained throughput SHALL be one payload per cycle while in_ready=1.
REQ-022 Payload order SHALL be preserved; no payload SHALL be duplicated or dropped except by in_flush or in_reset.
REQ-023 While out_valid=1 and in_ready=0, out_value SHALL remain stable.
REQ-024 Full condition (all valid bits 1, in_ready=0): out_ready SHALL be 0.
REQ-025 Full with in_ready=1: upstream and downstream transfers SHALL occur in the same cycle; out_count SHALL stay STAGES.
REQ-026 out_count SHALL equal the population count of the valid bits, registered, and consistent with them in every cycle.
REQ-027 in_flush=1 SHALL clear every valid bit at the next edge and SHALL override a simultaneous upstream transfer, which is discarded.
REQ-028 During in_flush=1, out_ready SHALL be forced to 1 and payload registers SHALL be left unchanged.
REQ-029 in_value SHALL be ignored while in_valid=0, and in_ready SHALL be ignored while out_valid=0.

Reset
REQ-030 in_reset=1 SHALL, at the next edge, clear all valid bits, giving out_valid=0 and out_count=0; this takes priority over in_flush and over all transfers.
REQ-031 With DFF_TYPE=DFF_R, reset SHALL also clear all payload registers to 0, giving out_value=0; with DFF, payload registers SHALL keep their contents.
REQ-032 Reset asserted mid-stream SHALL discard all in-flight payloads; the first upstream transfer after reset is released SHALL be the first to emerge.
REQ-033 During in_reset=1, out_ready SHALL be 0.

Structure
REQ-034 dff_type_t with values DFF and DFF_R SHALL remain in dev_package; no new package types are needed.
REQ-035 A sub-module d_elastic_stage SHALL implement one stage (payload register, valid bit, ready logic), instantiated STAGES times through a generate loop.
REQ-036 The top level SHALL contain only the stage chain, the flush/reset gating and the out_count register.

Verification
REQ-037 Streaming: T=logic[7:0], STAGES=3, in_ready=1, send 0x01..0x05 back-to-back -> out_value 0x01..0x05 on consecutive cycles, first on cycle 3, out_ready stays 1.
REQ-038 Backpressure: STAGES=3, in_ready=0, send 0xA0..0xA3 -> 0xA0..0xA2 accepted, out_ready=0 at the 4th, out_count=3; raise in_ready -> 0xA0, 0xA1, 0xA2, 0xA3 emerge in order.
REQ-039 Bubble collapse: STAGES=4, send 0x11, gap, 0x22 with in_ready=0 -> both packed in stages 3 and 2 with out_count=2 and out_ready=1.
REQ-040 Flush: STAGES=3, pipe full, in_flush=1 with in_valid=1, in_value=0x55 -> next cycle out_valid=0, out_count=0, and 0x55 never appears.
REQ-041 Reset: DFF_R, STAGES=2, pipe holding 0x7E, 0x7F, in_reset=1 for one cycle -> out_valid=0, out_value=0x00, out_count=0; same stimulus with DFF -> out_valid=0 and out_value unchanged.
REQ-042 Random: 10^4 cycles of random in_valid/in_ready/in_flush on a scoreboard model -> order preserved, no loss outside flush/reset, out_count always matches.
